// File: rtl/masked_pkg.sv
//==============================================================================
// Module      : masked_pkg
// Description : Shared types and share-pair helpers for the masked serial adder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package masked_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of unordered share pairs (i<j), one fresh bit each per ISW AND.
    function automatic int pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Pair ordering: (0,1),(0,2),...,(0,n-1),(1,2),...
    function automatic int pair_idx(input int i, input int j, input int n);
        return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

    function automatic int rbits(input int n, input int digit);
        return digit * pairs(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/masked_digit_adder.sv
//==============================================================================
// Module      : masked_digit_adder
// Description : Combinational DIGIT-bit share-domain ripple adder; each carry
//               uses an ISW masked AND fed by fresh randomness.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module masked_digit_adder
    import masked_pkg::*;
#(
    parameter int NSHARES = 3,
    parameter int DIGIT   = 8
) (
    input  logic [NSHARES*DIGIT-1:0]         a_dig_i,
    input  logic [NSHARES*DIGIT-1:0]         b_dig_i,
    input  logic [NSHARES-1:0]               carry_i,
    input  logic [rbits(NSHARES, DIGIT)-1:0] rnd_i,
    output logic [NSHARES*DIGIT-1:0]         sum_dig_o,
    output logic [NSHARES-1:0]               carry_o
);

    localparam int P = pairs(NSHARES);

    always_comb begin : p_ripple
        logic [NSHARES-1:0] c_v;
        logic [NSHARES-1:0] x_v;
        logic [NSHARES-1:0] y_v;
        logic [NSHARES-1:0] z_v;
        logic               r_v;
        c_v       = carry_i;
        x_v       = '0;
        y_v       = '0;
        z_v       = '0;
        r_v       = 1'b0;
        sum_dig_o = '0;
        for (int d = 0; d < DIGIT; d++) begin
            for (int i = 0; i < NSHARES; i++) begin
                sum_dig_o[i*DIGIT+d] = a_dig_i[i*DIGIT+d] ^ b_dig_i[i*DIGIT+d] ^ c_v[i];
                x_v[i]               = a_dig_i[i*DIGIT+d] ^ c_v[i];
                y_v[i]               = b_dig_i[i*DIGIT+d] ^ c_v[i];
            end
            for (int i = 0; i < NSHARES; i++) begin
                z_v[i] = x_v[i] & y_v[i];
            end
            // Cross terms: share i absorbs r_ij, share j absorbs the masked products.
            for (int i = 0; i < NSHARES; i++) begin
                for (int j = i + 1; j < NSHARES; j++) begin
                    r_v    = rnd_i[d*P + pair_idx(i, j, NSHARES)];
                    z_v[i] = z_v[i] ^ r_v;
                    z_v[j] = z_v[j] ^ (r_v ^ (x_v[i] & y_v[j])) ^ (x_v[j] & y_v[i]);
                end
            end
            c_v = z_v ^ c_v;
        end
        carry_o = c_v;
    end

endmodule

`default_nettype wire

// File: rtl/masked_serial_adder.sv
//==============================================================================
// Module      : masked_serial_adder
// Description : Digit-serial Boolean-masked adder; operands stay shared end to
//               end. Optional output re-masking: MASKED_SERIAL_ADDER_REFRESH_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module masked_serial_adder
    import masked_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NSHARES = 3,
    parameter int DIGIT   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NSHARES*WIDTH-1:0]         a_sh,
    input  logic [NSHARES*WIDTH-1:0]         b_sh,
    input  logic [NSHARES-1:0]               cin_sh,
    input  logic [rbits(NSHARES, DIGIT)-1:0] rnd,
`ifdef MASKED_SERIAL_ADDER_REFRESH_EN
    input  logic [(NSHARES-1)*(WIDTH+1)-1:0] rnd_ref,
`endif
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NSHARES*WIDTH-1:0]         sum_sh,
    output logic [NSHARES-1:0]               cout_sh,
    output logic                             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q;
    logic [NSHARES*WIDTH-1:0] a_q, b_q, sum_q;
    logic [NSHARES-1:0]       c_q, cout_q;
    logic                     out_valid_q;

    logic [NSHARES*DIGIT-1:0] w_a_dig, w_b_dig, w_s_dig;
    logic [NSHARES-1:0]       w_c_dig;
    logic [NSHARES*WIDTH-1:0] w_a_shift, w_b_shift, w_sum_shift;
    logic [NSHARES*WIDTH-1:0] w_mask_sum;
    logic [NSHARES-1:0]       w_mask_cout;
    logic                     w_accept, w_run, w_last;

    assign w_accept = (state_q == IDLE) && in_valid;
    assign w_run    = (state_q == RUN);
    assign w_last   = (k_q == KW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (w_last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Current digit sits in the low bits; finished sum digits enter from the top.
    for (genvar gi = 0; gi < NSHARES; gi++) begin : g_share
        assign w_a_dig[gi*DIGIT +: DIGIT]     = a_q[gi*WIDTH +: DIGIT];
        assign w_b_dig[gi*DIGIT +: DIGIT]     = b_q[gi*WIDTH +: DIGIT];
        assign w_a_shift[gi*WIDTH +: WIDTH]   = a_q[gi*WIDTH +: WIDTH] >> DIGIT;
        assign w_b_shift[gi*WIDTH +: WIDTH]   = b_q[gi*WIDTH +: WIDTH] >> DIGIT;
        assign w_sum_shift[gi*WIDTH +: WIDTH] = (sum_q[gi*WIDTH +: WIDTH] >> DIGIT)
                                              | (WIDTH'(w_s_dig[gi*DIGIT +: DIGIT]) << (WIDTH - DIGIT));
    end

    masked_digit_adder #(
        .NSHARES (NSHARES),
        .DIGIT   (DIGIT)
    ) u_digit (
        .a_dig_i   (w_a_dig),
        .b_dig_i   (w_b_dig),
        .carry_i   (c_q),
        .rnd_i     (rnd),
        .sum_dig_o (w_s_dig),
        .carry_o   (w_c_dig)
    );

`ifdef MASKED_SERIAL_ADDER_REFRESH_EN
    // The last share carries the XOR of all masks so the unshared value is preserved.
    always_comb begin : p_refresh
        logic [WIDTH:0] acc_v;
        logic [WIDTH:0] m_v;
        acc_v       = '0;
        m_v         = '0;
        w_mask_sum  = '0;
        w_mask_cout = '0;
        for (int i = 0; i < NSHARES - 1; i++) begin
            m_v                         = rnd_ref[i*(WIDTH+1) +: WIDTH+1];
            w_mask_sum[i*WIDTH +: WIDTH] = m_v[WIDTH-1:0];
            w_mask_cout[i]              = m_v[WIDTH];
            acc_v                       = acc_v ^ m_v;
        end
        w_mask_sum[(NSHARES-1)*WIDTH +: WIDTH] = acc_v[WIDTH-1:0];
        w_mask_cout[NSHARES-1]                 = acc_v[WIDTH];
    end
`else
    assign w_mask_sum  = '0;
    assign w_mask_cout = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            sum_q       <= '0;
            cout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (w_accept) begin
                a_q <= a_sh;
                b_q <= b_sh;
                c_q <= cin_sh;
                k_q <= '0;
            end else if (w_run) begin
                a_q <= w_a_shift;
                b_q <= w_b_shift;
                c_q <= w_c_dig;
                k_q <= k_q + KW'(1);
                if (w_last) begin
                    sum_q       <= w_sum_shift ^ w_mask_sum;
                    cout_q      <= w_c_dig ^ w_mask_cout;
                    out_valid_q <= 1'b1;
                end else begin
                    sum_q <= w_sum_shift;
                end
            end
            if ((state_q == DONE) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign sum_sh    = sum_q;
    assign cout_sh   = cout_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_masked_serial_adder.sv
//==============================================================================
// Module      : tb_masked_serial_adder
// Description : Directed vector table plus multi-cycle sequences for the masked
//               serial adder (WIDTH=64, NSHARES=3, DIGIT=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_masked_serial_adder;

    localparam int WIDTH   = 64;
    localparam int NSHARES = 3;
    localparam int DIGIT   = 8;
    localparam int NDIG    = WIDTH / DIGIT;
    localparam int RBITS   = DIGIT * NSHARES * (NSHARES - 1) / 2;
    localparam int NVEC    = 11;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        bit               plain;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [NSHARES*WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [NSHARES-1:0]       cin_sh, cout_sh;
    logic [RBITS-1:0]         rnd;
    logic                     out_valid, out_ready, busy;
`ifdef MASKED_SERIAL_ADDER_REFRESH_EN
    logic [(NSHARES-1)*(WIDTH+1)-1:0] rnd_ref;
`endif

    int total = 0;
    int bad   = 0;
    bit zero_rnd = 1'b0;

    always #5 clk = ~clk;

    masked_serial_adder #(
        .WIDTH   (WIDTH),
        .NSHARES (NSHARES),
        .DIGIT   (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sh      (a_sh),
        .b_sh      (b_sh),
        .cin_sh    (cin_sh),
        .rnd       (rnd),
`ifdef MASKED_SERIAL_ADDER_REFRESH_EN
        .rnd_ref   (rnd_ref),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_sh    (sum_sh),
        .cout_sh   (cout_sh),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rnd = zero_rnd ? '0 : RBITS'($urandom);
`ifdef MASKED_SERIAL_ADDER_REFRESH_EN
        for (int i = 0; i < (NSHARES-1)*(WIDTH+1); i++) rnd_ref[i] = 1'($urandom);
`endif
    endtask

    task automatic make_shares(input logic [WIDTH-1:0] v, input bit plain,
                               output logic [NSHARES*WIDTH-1:0] sh);
        logic [WIDTH-1:0] acc, r;
        acc = v;
        sh  = '0;
        for (int i = 1; i < NSHARES; i++) begin
            r = plain ? '0 : {$urandom, $urandom};
            sh[i*WIDTH +: WIDTH] = r;
            acc = acc ^ r;
        end
        sh[0 +: WIDTH] = acc;
    endtask

    function automatic logic [WIDTH-1:0] recomb(input logic [NSHARES*WIDTH-1:0] sh);
        logic [WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < NSHARES; i++) acc = acc ^ sh[i*WIDTH +: WIDTH];
        return acc;
    endfunction

    // Leaves the bench #1 after the accept edge (cycle 1 of the operation).
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input bit plain);
        logic [NSHARES*WIDTH-1:0] sa, sb;
        logic [NSHARES-1:0]       sc;
        make_shares(a, plain, sa);
        make_shares(b, plain, sb);
        sc = {NSHARES{1'b0}};
        for (int i = 1; i < NSHARES; i++) sc[i] = plain ? 1'b0 : 1'($urandom);
        sc[0] = cin ^ (^sc[NSHARES-1:1]);
        zero_rnd = plain;
        if (plain) rnd = '0;
        a_sh     = sa;
        b_sh     = sb;
        cin_sh   = sc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic full_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input bit plain,
                           input logic [WIDTH-1:0] es, input logic ec, input bit chk_lat);
        int lat;
        start_op(a, b, cin, plain);
        wait_out(lat);
        if (chk_lat) chk({nm, " latency"}, 256'(lat), 256'(NDIG + 1));
        chk({nm, " sum"}, 256'(recomb(sum_sh)), 256'(es));
        chk({nm, " cout"}, 256'(^cout_sh), 256'(ec));
        if (!out_valid) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end else begin
            finish_op();
        end
        if (chk_lat) chk({nm, " in_ready after handshake"}, 256'(in_ready), 256'(1));
    endtask

    vec_t tbl [NVEC];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NSHARES*WIDTH-1:0] s_hold;
        logic [NSHARES-1:0]       c_hold;
        logic [WIDTH-1:0]         ra, rb;
        logic                     rc;
        logic [WIDTH:0]           model;
        int                       seen;

        tbl[0]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'd12, 1'b0};
        tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1};
        tbl[2]  = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0};
        tbl[3]  = '{64'd100, 64'd23, 1'b0, 1'b0, 64'd123, 1'b0};
        tbl[4]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd1, 1'b1};
        tbl[5]  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[6]  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 64'd0, 1'b1};
        tbl[7]  = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
        tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[9]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
        tbl[10] = '{64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 64'h100E_100E_100E_100E, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_sh      = '0;
        b_sh      = '0;
        cin_sh    = '0;
        rnd       = '0;
`ifdef MASKED_SERIAL_ADDER_REFRESH_EN
        rnd_ref   = '0;
`endif
        tick();
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        chk("reset in_ready", 256'(in_ready), 256'(1));
        chk("reset out_valid", 256'(out_valid), 256'(0));
        chk("reset busy", 256'(busy), 256'(0));
        chk("reset sum_sh", 256'(sum_sh), 256'(0));
        chk("reset cout_sh", 256'(cout_sh), 256'(0));

        for (int i = 0; i < NVEC; i++) begin
            full_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].plain,
                    tbl[i].exp_sum, tbl[i].exp_cout, 1'b1);
        end

        for (int i = 0; i < 100; i++) begin
            ra    = {$urandom, $urandom};
            rb    = {$urandom, $urandom};
            rc    = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            full_op($sformatf("rand%0d", i), ra, rb, rc, 1'b0, model[WIDTH-1:0], model[WIDTH], 1'b0);
        end

        // Latency, busy window and backpressure in DONE.
        start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        for (int cyc = 1; cyc <= NDIG + 1; cyc++) begin
            chk($sformatf("busy cyc%0d", cyc), 256'(busy), 256'(1));
            chk($sformatf("out_valid cyc%0d", cyc), 256'(out_valid), 256'(cyc == NDIG + 1));
            if (cyc < NDIG + 1) tick();
        end
        s_hold   = sum_sh;
        c_hold   = cout_sh;
        a_sh     = ~a_sh;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d out_valid", i), 256'(out_valid), 256'(1));
            chk($sformatf("bp%0d sum_sh", i), 256'(sum_sh), 256'(s_hold));
            chk($sformatf("bp%0d cout_sh", i), 256'(cout_sh), 256'(c_hold));
            chk($sformatf("bp%0d in_ready", i), 256'(in_ready), 256'(0));
        end
        chk("bp sum", 256'(recomb(sum_sh)), 256'(64'h2222_2222_2222_2212));
        chk("bp cout", 256'(^cout_sh), 256'(0));
        finish_op();
        in_valid = 1'b0;
        chk("post-bp in_ready", 256'(in_ready), 256'(1));
        chk("post-bp busy", 256'(busy), 256'(0));
        chk("post-bp out_valid", 256'(out_valid), 256'(0));

        // Reset pulsed during the third RUN cycle abandons the operation.
        start_op(64'd999, 64'd1, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-run rst in_ready", 256'(in_ready), 256'(1));
        chk("mid-run rst busy", 256'(busy), 256'(0));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("mid-run rst no out_valid", 256'(seen), 256'(0));
        full_op("after rst", 64'd100, 64'd23, 1'b0, 1'b0, 64'd123, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/masked_serial_adder.md
# masked_serial_adder

Digit-serial, fully share-domain adder: accepts both operands and the carry-in already split into NSHARES Boolean shares, adds DIGIT bits per clock, and returns the sum and carry-out as shares. The operands are never recombined. Each carry bit is computed with an ISW masked AND fed by an external fresh-randomness port. It is the sequential, parametrised successor to the combinational masked ripple-carry adder and sits between the share generator and downstream masked datapath stages.

## Interface
- WIDTH, 64: operand width in bits. Must be a multiple of DIGIT.
- NSHARES, 3: number of Boolean shares. Must be at least 2.
- DIGIT, 8: bits processed per RUN cycle. Must satisfy 1 ≤ DIGIT ≤ WIDTH.
- Derived constants:
  - NDIG = WIDTH/DIGIT.
  - P = NSHARES*(NSHARES-1)/2.
  - RBITS = DIGIT*P.
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand shares present
- in_ready  out  1  block can accept operands
- a_sh  in  NSHARES*WIDTH  shares of a; share i is bits [i*WIDTH +: WIDTH]; a = XOR of all shares
- b_sh  in  NSHARES*WIDTH  shares of b, same layout
- cin_sh  in  NSHARES  shares of the carry-in; bit i is share i
- rnd  in  RBITS  fresh randomness, sampled on every RUN cycle
- out_valid  out  1  result shares valid
- out_ready  in  1  consumer accepts the result
- sum_sh  out  NSHARES*WIDTH  shares of (a+b+cin) mod 2^WIDTH, same layout as a_sh
- cout_sh  out  NSHARES  shares of the carry-out
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid && in_ready: latch a_sh and b_sh into shift registers, load the carry register with cin_sh, set digit counter k=0, go to RUN.
- **RUN**
  - Per-digit computation:
    - Digit k uses the low DIGIT bits of each operand share register.
    - Per bit, per share: s = a^b^c.
    - Carry is computed as c' = ((a^c) AND (b^c)) ^ c. The AND is the masked ISW AND.
    - Bits ripple LSB to MSB within the digit.
  - Register updates:
    - Sum digit shifts into the top of the result register; operand registers shift right by DIGIT.
    - Carry register takes the carry out of the digit; k increments.
  - When k==NDIG-1, go to DONE.
- **ISW AND** on shares x and y, using one fresh bit r_ij per pair i<j:
  - Per-pair terms: z_ij = r_ij; z_ji = (r_ij ^ x_i&y_j) ^ x_j&y_i.
  - Output share: z_i = x_i&y_i ^ (XOR over j≠i of z_ij).
- **rnd layout:** bit d*P+p belongs to digit bit d and pair p. Pairs are ordered (0,1),(0,2),…,(0,N-1),(1,2),…
- **DONE**
  - out_valid=1. sum_sh and cout_sh are stable and held until out_ready.
  - On out_ready, go to IDLE.
  - in_ready=0 throughout DONE; no accept in the same cycle as the output handshake.
- rnd is ignored outside RUN.
- in_valid is ignored outside IDLE.

## Timing
- Accept edge at cycle T.
- RUN occupies cycles T+1 … T+NDIG.
- out_valid rises at T+NDIG+1 (latency NDIG+1).
- Output handshake at cycle D → in_ready=1 at D+1.
- Minimum accept-to-accept interval: NDIG+2 cycles.
- Outputs are registered, except in_ready and busy, which are decoded from state.
- Reset values:
  - state=IDLE, out_valid=0, busy=0.
  - sum_sh=0, cout_sh=0, internal registers=0.
  - in_ready=1 from the first cycle after rst deasserts. Any handshake while rst=1 is ignored.
- Reset asserted mid-RUN or in DONE:
  - The operation is abandoned; no out_valid.
  - The block is idle on the next cycle.
- NDIG=1 (DIGIT=WIDTH): a single RUN cycle; latency 2.
- Overflow: the carry out of bit WIDTH-1 appears only in cout_sh; sum wraps mod 2^WIDTH.

## Configuration
- MASKED_SERIAL_ADDER_REFRESH_EN defined:
  - Adds port rnd_ref, in, (NSHARES-1)*(WIDTH+1), sampled on the last RUN cycle.
  - Mask layout: mask m_i for share i<NSHARES-1 is bits [i*(WIDTH+1) +: WIDTH+1], with {cout bit, sum bits}.
  - On entry to DONE, shares i<NSHARES-1 are XORed with m_i; share NSHARES-1 is XORed with the XOR of all m_i.
  - The unshared value is unchanged.
- Undefined: no rnd_ref port; result shares are output exactly as computed.

## Structure
- Package masked_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Functions: pairs(n) returning P; pair_idx(i,j); rbits(n,digit).
- Sub-module masked_digit_adder: combinational, DIGIT-bit share-domain ripple with ISW ANDs.
  - Inputs: operand digit shares, carry shares, rnd.
  - Outputs: sum digit shares, carry shares.
- Top level holds the FSM, counter, shift registers, output registers and the optional refresh.

## Test plan
- rnd=0, share0=value, other shares 0; a=5, b=7, cin=0 → recombined sum=12, cout=0.
- a=2^64-1, b=1, cin=0, random shares → recombined sum=0, cout=1; cin=1 with a=b=0 → sum=1, cout=0.
- Random shares and random rnd, 10k vectors, WIDTH=64 with DIGIT ∈ {1,8,64} → recombined results equal a+b+cin.
- Latency: WIDTH=64, DIGIT=8, accept at cycle 0 → out_valid at cycle 9, busy=1 on cycles 1–9.
- Backpressure: out_ready held low 5 cycles in DONE → out_valid stays 1, shares stable, in_ready=0; release → in_ready=1 next cycle.
- rst pulsed at RUN cycle 3 → no out_valid, in_ready=1 next cycle; next operation a=100, b=23 → 123.
